// File: rtl/input_debouncer.sv
// Per-channel debouncer with registered level and single-cycle rise/fall pulses.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer on every input bit.
module input_debouncer #(
  parameter int unsigned N             = 1,
  parameter int unsigned STABLE_CYCLES = 12000,
  parameter logic [N-1:0] INIT         = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic [N-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= INIT;
      sync2_q <= INIT;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = in;
`endif

  logic [N-1:0]    level_q, level_d;
  logic [N-1:0]    rise_q, rise_d;
  logic [N-1:0]    fall_q, fall_d;
  logic [CntW-1:0] cnt_q [N];
  logic [CntW-1:0] cnt_d [N];

  // Any matching sample clears the count, so only an unbroken run of mismatches is accepted.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = s[i];
          rise_d[i]  = s[i];
          fall_d[i]  = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= INIT;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: directed scenarios then random bouncing inputs,
// checked against a sliding-window model of "last STABLE_CYCLES samples all disagree".
module tb_input_debouncer;

  localparam int unsigned NCh    = 2;
  localparam int unsigned Stable = 4;
  localparam logic [1:0]  Init   = 2'b00;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCh-1:0] in = '0;
  logic [NCh-1:0] level, rise, fall;

  input_debouncer #(
    .N            (NCh),
    .STABLE_CYCLES(Stable),
    .INIT         (Init)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {level, rise, fall} after each rising edge.
  logic [5:0] exp_q[$];

  // Reference model state.
  logic [1:0] m_level = Init;
  bit         hist [NCh][$];
  logic [1:0] p1 = Init, p2 = Init;

  // Called just before a rising edge with the values that edge will sample.
  task automatic model_step(input logic [1:0] v, input logic r);
    logic [1:0] s, rs, fl;
    bool_all_t: begin end
    rs = '0;
    fl = '0;
    if (!r) begin
      m_level = Init;
      p1 = Init;
      p2 = Init;
      for (int c = 0; c < NCh; c++) hist[c].delete();
    end else begin
`ifdef DEBOUNCE_SYNC_EN
      s  = p2;
      p2 = p1;
      p1 = v;
`else
      s = v;
`endif
      for (int c = 0; c < NCh; c++) begin
        bit all_diff;
        hist[c].push_back(s[c]);
        if (hist[c].size() > Stable) void'(hist[c].pop_front());
        all_diff = (hist[c].size() == Stable);
        foreach (hist[c][k]) if (hist[c][k] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[c] = s[c];
          rs[c] = s[c];
          fl[c] = ~s[c];
        end
      end
    end
    exp_q.push_back({m_level, rs, fl});
  endtask

  task automatic cyc(input logic [1:0] v, input logic r);
    @(negedge clk);
    in    = v;
    rst_n = r;
    model_step(v, r);
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    for (int k = 0; k < n; k++) cyc(v, 1'b1);
  endtask

  // Monitor: every edge presents one output triple.
  always @(posedge clk) begin
    logic [5:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({level, rise, fall} !== e) begin
        n_fail++;
        $display("FAIL out t=%0t level/rise/fall got %b/%b/%b want %b/%b/%b",
                 $time, level, rise, fall, e[5:4], e[3:2], e[1:0]);
      end
      n_tests++;
      if ((rise & fall) != 2'b00) begin
        n_fail++;
        $display("FAIL excl t=%0t rise=%b fall=%b want no overlap", $time, rise, fall);
      end
    end
  end

  initial begin
    logic [1:0] v;
    // Reset hold with inputs high, then release.
    for (int k = 0; k < 3; k++) cyc(2'b11, 1'b0);
    hold(2'b11, 6);
    // Back to 00, then clean press on channel 0.
    hold(2'b00, 6);
    hold(2'b01, 6);
    hold(2'b00, 6);
    // Glitch reject: 3 cycles high.
    hold(2'b01, 3);
    hold(2'b00, 4);
    // Bounce: 1,1,0,1,1,1,1.
    hold(2'b01, 2);
    hold(2'b00, 1);
    hold(2'b01, 6);
    hold(2'b00, 6);
    // Independent channels.
    hold(2'b11, 6);
    hold(2'b01, 6);
    hold(2'b00, 6);
    // Reset mid-count.
    hold(2'b01, 2);
    cyc(2'b01, 1'b0);
    hold(2'b01, 8);
    hold(2'b00, 6);
    // Random runs with bounded durations and occasional reset.
    v = 2'b00;
    for (int k = 0; k < 600; k++) begin
      v[$urandom_range(1, 0)] = 1'($urandom_range(1, 0));
      if ($urandom_range(99, 0) == 0) cyc(v, 1'b0);
      else hold(v, $urandom_range(7, 1));
    end
    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
